// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared encodings and address helpers for the data-memory path
package proc_pkg;

    // Responder FSM encoding; values are fixed so traces read the same across blocks
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } dmem_state_e;

    localparam int ADDR_WIDTH = 32;
    // Byte address -> word address slice
    localparam int WORD_LSB   = 2;
    localparam int WORD_MSB   = ADDR_WIDTH - 1;
    // Wait-state counter
    localparam int CNT_WIDTH  = 4;
    localparam int WAIT_MAX   = (1 << CNT_WIDTH) - 1;

    // Rejects misaligned byte addresses and word indices beyond the array
    function automatic logic addr_error(input logic [ADDR_WIDTH-1:0] addr,
                                        input int unsigned         depth);
        logic [ADDR_WIDTH-1:0] word;
        word = addr >> WORD_LSB;
        return (addr[WORD_LSB-1:0] != '0) || (word >= ADDR_WIDTH'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the core and the data memory
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    import proc_pkg::*;

    logic                  DMEM_req;
    logic                  DMEM_we;
    logic [ADDR_WIDTH-1:0] DMEM_address;
    logic [DATA_WIDTH-1:0] DMEM_data_in;
    logic                  DMEM_ready;
    logic [DATA_WIDTH-1:0] DMEM_data_out;
    logic                  DMEM_error;
    logic                  DMEM_busy;

    // Core side issues accesses and observes completion
    modport master (
        output DMEM_req, DMEM_we, DMEM_address, DMEM_data_in,
        input  DMEM_ready, DMEM_data_out, DMEM_error, DMEM_busy
    );

    // Memory side serves accesses
    modport slave (
        input  DMEM_req, DMEM_we, DMEM_address, DMEM_data_in,
        output DMEM_ready, DMEM_data_out, DMEM_error, DMEM_busy
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: synchronous write, asynchronous read, never cleared
module dmem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64,
    localparam int IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Write port; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with configurable wait states and access checks
module dmem_responder
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    dmem_responder_if.slave  dmem
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned DEPTH_U = DEPTH_WORDS;
    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES);
    // With no wait states the request goes straight to the response cycle
    localparam dmem_state_e FIRST_STATE = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait_cycles
            $error("dmem_responder: WAIT_CYCLES must be within 0..15");
        end
    endgenerate

    dmem_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_err;
    logic [IDX_W-1:0]      acc_idx;
    logic                  enter_resp;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Access fields: live inputs when leaving IDLE (only reachable with zero wait
    // states), otherwise the copies captured when the request was accepted
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            acc_we    = dmem.DMEM_we;
            acc_addr  = dmem.DMEM_address;
            acc_wdata = dmem.DMEM_data_in;
        end
    end

    assign acc_err    = addr_error(acc_addr, DEPTH_U);
    assign acc_idx    = acc_addr[WORD_LSB +: IDX_W];
    // RESP always returns to IDLE, so reaching RESP next always means entering it
    assign enter_resp = (state_d == S_RESP);
    assign mem_we     = enter_resp && acc_we && !acc_err;

    dmem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (SYS_clk),
        .we    (mem_we),
        .waddr (acc_idx),
        .wdata (acc_wdata),
        .raddr (acc_idx),
        .rdata (mem_rdata)
    );

    // Next-state decode; requests are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (dmem.DMEM_req) begin
                    state_d = FIRST_STATE;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, wait counter and request capture
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && dmem.DMEM_req) begin
                cnt_q   <= WAIT_LOAD;
                we_q    <= dmem.DMEM_we;
                addr_q  <= dmem.DMEM_address;
                wdata_q <= dmem.DMEM_data_in;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    // Completion result, loaded on the edge entering RESP and held until the next one
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else if (enter_resp) begin
            err_q <= acc_err;
            if (acc_err) begin
                data_out_q <= '0;
            end else if (!acc_we) begin
                data_out_q <= mem_rdata;
            end
        end
    end

    assign dmem.DMEM_ready    = (state_q == S_RESP);
    assign dmem.DMEM_error    = (state_q == S_RESP) && err_q;
    assign dmem.DMEM_busy     = (state_q != S_IDLE);
    assign dmem.DMEM_data_out = data_out_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int WAIT_A = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t sb_a[$];
    exp_t sb_b[$];
    vec_t vecs[18];
    vec_t bvecs[6];
    int   n_checks = 0;
    int   n_errors = 0;

    dmem_responder_if #(.DATA_WIDTH(32)) ifa ();
    dmem_responder_if #(.DATA_WIDTH(32)) ifb ();

    dmem_responder #(
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (64),
        .WAIT_CYCLES (WAIT_A)
    ) dut_a (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .dmem      (ifa)
    );

    dmem_responder #(
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (64),
        .WAIT_CYCLES (0)
    ) dut_b (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .dmem      (ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_a(input vec_t v, input bit push);
        @(negedge clk);
        ifa.DMEM_req     = 1'b1;
        ifa.DMEM_we      = v.we;
        ifa.DMEM_address = v.addr;
        ifa.DMEM_data_in = v.wdata;
        if (push) sb_a.push_back('{v.exp_data, v.exp_err});
        @(posedge clk);
        #1;
        ifa.DMEM_req = 1'b0;
    endtask

    task automatic wait_resp_a(input string name);
        int   busy_cnt = 0;
        int   lat = 0;
        bit   seen = 1'b0;
        exp_t e;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (ifa.DMEM_busy) busy_cnt++;
            if (ifa.DMEM_ready) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk($sformatf("%s ready_seen", name), 32'(seen), 32'd1);
        if (seen) begin
            if (sb_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s scoreboard: got unexpected ready, expected no response", name);
            end else begin
                e = sb_a.pop_front();
                chk($sformatf("%s data_out", name), ifa.DMEM_data_out, e.data);
                chk($sformatf("%s error", name), 32'(ifa.DMEM_error), 32'(e.err));
                chk($sformatf("%s latency", name), lat, WAIT_A + 1);
                chk($sformatf("%s busy_cycles", name), busy_cnt, WAIT_A + 1);
            end
            @(negedge clk);
            chk($sformatf("%s ready_after", name), 32'(ifa.DMEM_ready), 32'd0);
            chk($sformatf("%s busy_after", name), 32'(ifa.DMEM_busy), 32'd0);
        end
    endtask

    initial begin
        int   pulses;
        exp_t e;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'h1234_5678, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0000};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 32'h0000_0024, 32'h2424_2424, 1'b0, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 32'h0000_0028, 32'h2828_2828, 1'b0, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 32'h0000_0102, 32'h0,         1'b1, 32'h0000_0000};
        vecs[12] = '{1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vecs[13] = '{1'b1, 32'h0000_0000, 32'h0000_C0DE, 1'b0, 32'hA5A5_A5A5};
        vecs[14] = '{1'b1, 32'h0000_0100, 32'h7777_7777, 1'b1, 32'h0000_0000};
        vecs[15] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_C0DE};
        vecs[16] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
        vecs[17] = '{1'b0, 32'h0000_0024, 32'h0,         1'b0, 32'h2424_2424};

        bvecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_AAAA, 1'b0, 32'h0000_0000};
        bvecs[1] = '{1'b1, 32'h0000_0004, 32'h5555_BBBB, 1'b0, 32'h0000_0000};
        bvecs[2] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_AAAA};
        bvecs[3] = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h5555_BBBB};
        bvecs[4] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_AAAA};
        bvecs[5] = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h5555_BBBB};

        ifa.DMEM_req = 1'b0; ifa.DMEM_we = 1'b0; ifa.DMEM_address = '0; ifa.DMEM_data_in = '0;
        ifb.DMEM_req = 1'b0; ifb.DMEM_we = 1'b0; ifb.DMEM_address = '0; ifb.DMEM_data_in = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a ready", 32'(ifa.DMEM_ready), 32'd0);
        chk("rst_a error", 32'(ifa.DMEM_error), 32'd0);
        chk("rst_a busy", 32'(ifa.DMEM_busy), 32'd0);
        chk("rst_a data_out", ifa.DMEM_data_out, 32'd0);
        chk("rst_b ready", 32'(ifb.DMEM_ready), 32'd0);
        chk("rst_b busy", 32'(ifb.DMEM_busy), 32'd0);
        chk("rst_b data_out", ifb.DMEM_data_out, 32'd0);
        rst = 1'b0;

        // Table-driven accesses on the two-wait-state instance
        for (int i = 0; i < 18; i++) begin
            start_a(vecs[i], 1'b1);
            wait_resp_a($sformatf("vec%0d", i));
        end

        // Inputs wander during WAIT; only the captured request may be written
        start_a('{1'b1, 32'h0000_0020, 32'h0BAD_C0DE, 1'b0, 32'h2424_2424}, 1'b1);
        fork
            wait_resp_a("scramble_wr");
            begin
                ifa.DMEM_req = 1'b1; ifa.DMEM_we = 1'b1;
                ifa.DMEM_address = 32'h0000_0024; ifa.DMEM_data_in = 32'hFFFF_FFFF;
                @(posedge clk); #1;
                ifa.DMEM_address = 32'h0000_0028; ifa.DMEM_data_in = 32'hEEEE_EEEE;
                @(posedge clk); #1;
                ifa.DMEM_req = 1'b0; ifa.DMEM_we = 1'b0;
            end
        join
        start_a('{1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0BAD_C0DE}, 1'b1);
        wait_resp_a("scramble_rd20");
        start_a('{1'b0, 32'h0000_0024, 32'h0, 1'b0, 32'h2424_2424}, 1'b1);
        wait_resp_a("scramble_rd24");
        start_a('{1'b0, 32'h0000_0028, 32'h0, 1'b0, 32'h2828_2828}, 1'b1);
        wait_resp_a("scramble_rd28");

        // Reset in the middle of a write's wait states aborts it
        start_a('{1'b1, 32'h0000_0030, 32'h5A5A_5A5A, 1'b0, 32'h0}, 1'b0);
        @(negedge clk);
        chk("abort busy_before", 32'(ifa.DMEM_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 32'(ifa.DMEM_busy), 32'd0);
        chk("abort ready", 32'(ifa.DMEM_ready), 32'd0);
        chk("abort error", 32'(ifa.DMEM_error), 32'd0);
        chk("abort data_out", ifa.DMEM_data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ifa.DMEM_ready) pulses++;
        end
        chk("abort ready_pulses", pulses, 0);
        chk("abort busy_idle", 32'(ifa.DMEM_busy), 32'd0);
        start_a('{1'b0, 32'h0000_0030, 32'h0, 1'b0, 32'hA5A5_A5A5}, 1'b1);
        wait_resp_a("abort_readback");

        // Zero wait states, request held high: a completion every second cycle
        pulses = 0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("b_ready%0d", k), 32'(ifb.DMEM_ready), 32'(k % 2));
                if (ifb.DMEM_ready) begin
                    pulses++;
                    if (sb_b.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL b_scoreboard%0d: got unexpected ready, expected no response", k);
                    end else begin
                        e = sb_b.pop_front();
                        chk($sformatf("b_data%0d", k), ifb.DMEM_data_out, e.data);
                        chk($sformatf("b_error%0d", k), 32'(ifb.DMEM_error), 32'(e.err));
                    end
                end
            end
            if (k % 2 == 0 && k < 12) begin
                ifb.DMEM_req     = 1'b1;
                ifb.DMEM_we      = bvecs[k/2].we;
                ifb.DMEM_address = bvecs[k/2].addr;
                ifb.DMEM_data_in = bvecs[k/2].wdata;
                sb_b.push_back('{bvecs[k/2].exp_data, bvecs[k/2].exp_err});
            end else if (k == 12) begin
                ifb.DMEM_req = 1'b0;
            end
        end
        chk("b_pulses", pulses, 6);
        chk("b_sb_left", sb_b.size(), 0);
        chk("a_sb_left", sb_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
